// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of the single-port data memory.
// Define DMEM_ARB_LOCK_EN to enable bounded locked bursts (OWN0/OWN1 states).
module dmem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              lock0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   rd_vld_q, rd_vld_d;
    logic   rd_id_q, rd_id_d;
    logic   acc0, acc1;

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant decode; a grant is only ever issued to an active request
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            case (state_q)
                OWN0: gnt0 = req0;
                OWN1: gnt1 = req1;
                default: begin
                    if (req0 && req1) begin
                        gnt0 = last_q;
                        gnt1 = !last_q;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
            endcase
        end
    end

    assign acc0 = gnt0;
    assign acc1 = gnt1;

    assign address_dmem = gnt1 ? addr1 : addr0;
    assign data         = gnt1 ? wdata1 : wdata0;
    assign wren         = (gnt0 & we0) | (gnt1 & we1);

    always_comb begin
        last_d   = last_q;
        rd_vld_d = 1'b0;
        rd_id_d  = rd_id_q;
        if (acc1) begin
            last_d   = 1'b1;
            rd_vld_d = !we1;
            rd_id_d  = 1'b1;
        end else if (acc0) begin
            last_d   = 1'b0;
            rd_vld_d = !we0;
            rd_id_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            last_q   <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_id_q  <= 1'b0;
        end else begin
            last_q   <= last_d;
            rd_vld_q <= rd_vld_d;
            rd_id_q  <= rd_id_d;
        end
    end

    // Gated by reset so a read accepted just before reset never returns
    assign rvalid0 = reset & rd_vld_q & !rd_id_q;
    assign rvalid1 = reset & rd_vld_q & rd_id_q;
    assign rdata0  = q_dmem;
    assign rdata1  = q_dmem;

`ifdef DMEM_ARB_LOCK_EN
    localparam int BEATS_W = $clog2(MAX_LOCK + 1);
    localparam logic [BEATS_W-1:0] LAST_BEAT = BEATS_W'(MAX_LOCK - 1);

    logic [BEATS_W-1:0] beats_q, beats_d;

    // Next-state: beats counts accepted beats of the current burst
    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        case (state_q)
            IDLE: begin
                if (acc0 && lock0) begin
                    state_d = OWN0;
                    beats_d = BEATS_W'(1);
                end else if (acc1 && lock1) begin
                    state_d = OWN1;
                    beats_d = BEATS_W'(1);
                end
            end
            OWN0: begin
                if (!req0) begin
                    state_d = IDLE;
                    beats_d = '0;
                end else if (acc0) begin
                    if (lock0 && (beats_q < LAST_BEAT)) begin
                        beats_d = beats_q + BEATS_W'(1);
                    end else begin
                        state_d = IDLE;
                        beats_d = '0;
                    end
                end
            end
            OWN1: begin
                if (!req1) begin
                    state_d = IDLE;
                    beats_d = '0;
                end else if (acc1) begin
                    if (lock1 && (beats_q < LAST_BEAT)) begin
                        beats_d = beats_q + BEATS_W'(1);
                    end else begin
                        state_d = IDLE;
                        beats_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beats_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            beats_q <= '0;
        end else begin
            beats_q <= beats_d;
        end
    end
`else
    localparam int unused_max_lock = MAX_LOCK;
    logic unused_lock;

    assign unused_lock = lock0 ^ lock1;
    assign state_d     = IDLE;
`endif

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the single-port data memory. It shares one synchronous-read, one-cycle-latency `dmem` port between the processor's load/store path (requester 0) and a debug/loader port (requester 1), which is used for program-data preload and run-time inspection. It sits between those two masters and the `dmem` instance, and runs in the `dmem_clock` domain. It provides round-robin fairness, returns read data tagged to the requester that issued the read, and optionally supports bounded locked bursts.

## Interface
- `ADDR_W`, 12, dmem word-address width
- `DATA_W`, 32, data width
- `MAX_LOCK`, 8, maximum accepted beats per locked burst (≥2)
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low; sampled on the rising edge of `clock`
- `req0`/`req1`  in  1  access request, held until granted
- `we0`/`we1`  in  1  1 = write, 0 = read
- `addr0`/`addr1`  in  ADDR_W  word address
- `wdata0`/`wdata1`  in  DATA_W  write data
- `lock0`/`lock1`  in  1  request burst ownership (only with `DMEM_ARB_LOCK_EN`)
- `gnt0`/`gnt1`  out  1  access accepted this cycle when high with the matching req
- `rvalid0`/`rvalid1`  out  1  read data valid
- `rdata0`/`rdata1`  out  DATA_W  read data
- `address_dmem`  out  ADDR_W  to dmem
- `data`  out  DATA_W  to dmem
- `wren`  out  1  to dmem
- `q_dmem`  in  DATA_W  from dmem, valid one cycle after the address is presented

## Operation
- Registered state:
  - `last` (last served requester), reset 0, so requester 1 wins the first tie.
  - FSM state ∈ {IDLE, OWN0, OWN1}, reset IDLE.
  - `rd_tag` (valid + id).
  - `beats` counter, ceil(log2(MAX_LOCK+1)) bits.
- Grant logic is combinational from the req inputs and the registered state:
  - IDLE, one request: grant it.
  - IDLE, both requesting: grant the requester ≠ `last`.
  - OWNn: grant only n; the other requester waits with gnt low.
- The winner's `addr`, `wdata` and `we & req` drive `address_dmem`, `data` and `wren`. With no grant, `wren` = 0 and the address/data hold the requester-0 values.
- Accept = `reqN & gntN` at a rising edge. On accept, `last` ← N.
- An accepted read sets `rd_tag` ← {1, N}. In the next cycle `rvalidN` = 1 and `rdataN` = `q_dmem`.
- The rvalid of the non-tagged requester is 0. `rdataN` is don't-care when `rvalidN` = 0 (it is driven with `q_dmem`).
- An accepted write produces no rvalid.
- Back-to-back accepts are allowed every cycle. A read response and a new accept in the same cycle are independent.
- FSM (lock builds only):
  - IDLE→OWNn: on an accept from n with `lockN` = 1; `beats` ← 1.
  - OWNn, accept with `lockN` = 1 and `beats` < MAX_LOCK−1: stay; `beats` increments.
  - OWNn→IDLE on any of:
    - an accept with `lockN` = 0 (final beat);
    - `reqN` = 0 in a cycle (owner idle; release immediately);
    - an accept that makes `beats` reach MAX_LOCK (forced release). On a forced release `last` ← n, so a waiting peer wins next.
- `lock` is ignored on non-accepted cycles.

## Timing
- Grant latency is 0 cycles: gnt is valid in the same cycle as req when that requester wins.
- Read latency: accept at edge k, `rvalid` high during cycle k+1, for exactly one cycle per read.
- A write commits to dmem at the accept edge.
- While `reset` = 0:
  - gnt0/gnt1 = 0, `wren` = 0, rvalid0/rvalid1 = 0 (forced combinationally and in registers);
  - `address_dmem`/`data` = requester-0 values;
  - `last` = 0, state = IDLE, `beats` = 0, `rd_tag` cleared.
- Reset mid-burst or mid-read: ownership is dropped, and a read accepted in the edge before reset gets no rvalid.
- Simultaneous owner release and peer request: the peer is granted in the cycle after release, not in the release cycle.

## Configuration
- `DMEM_ARB_LOCK_EN` defined: the lock inputs, the OWN0/OWN1 states and the `beats` counter are present, with the behaviour above.
- Not defined: the lock ports still exist and are ignored, the FSM is fixed at IDLE (pure round-robin), and `MAX_LOCK` is unused.

## Test plan
- Reset held low 3 cycles with req0 = req1 = 1, we0 = 1 → gnt0 = gnt1 = wren = rvalid = 0 throughout. First cycle after release: gnt1 = 1, gnt0 = 0.
- req0 alone writes 0xDEADBEEF to addr 0x010, then reads 0x010 → gnt0 in the same cycle; next cycle rvalid0 = 1, rdata0 = 0xDEADBEEF, rvalid1 = 0.
- req0 and req1 both hold reads for 6 cycles (addr 0x001 / 0x002) → grants alternate 1,0,1,0,1,0, and each rvalid pulses one cycle after the matching grant.
- Lock build: req1 with lock1 = 1 for 10 beats while req0 is held, MAX_LOCK = 8 → gnt1 for 8 consecutive beats, then gnt0 on the 9th cycle, gnt1 after that.
- Lock build: owner 0 drops req0 mid-burst after 3 beats while req1 is pending → state IDLE; gnt1 is asserted in the cycle after req0 falls.
- Reset pulled low the cycle after a read accept by requester 1 → rvalid1 stays 0; after release all outputs match the reset values.
